// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the matrix multiplier arbiter slice.
//   arb_state_t  : arbiter FSM states
//   MATRIX_NELEM : element pairs per 4x4 job
//   MATRIX_W     : default fixed-point element width (12:10 format)
//   mat_flat_t   : 4x4 result, element 0 (cC1) in the LSBs
package matrix_pkg;

  localparam int unsigned MATRIX_NELEM = 16;
  localparam int unsigned MATRIX_W     = 12;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOAD,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef logic [MATRIX_NELEM-1:0][MATRIX_W-1:0] mat_flat_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority pick over NREQ request lines.
//   req : request vector
//   ptr : highest-priority index for this pick
//   gnt : one-hot grant (zero when no request)
//   idx : binary index of the granted line (0 when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;
  logic            found;

  // Requests at or above ptr win first; if none, wrap to the lowest request.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      hi_mask[i] = (i >= 32'(ptr));
    end
    masked = req & hi_mask;
    pick   = (|masked) ? masked : req;
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i] && !found) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_mult_arbiter.sv
// matrix_mult_arbiter: shares one matrix_4x4_mult between NREQ requesters with
// round-robin arbitration. The owner streams 16 (a,b) pairs through to the
// multiplier; the 4x4 result is registered and returned to the owner only.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_a/req_b: per-requester element stream in, req_ready back
//   m_valid/m_a/m_b      : element stream to multiplier, m_ready from it
//   mr_valid/mr_c        : multiplier result in, mr_ready to it
//   rsp_valid/rsp_c      : result to owner (one-hot valid), rsp_ready back
//   grant_id, busy       : current owner and job-in-progress flag
// Optional build macro MATRIX_ARB_PERF_EN adds perf_jobs (completed jobs,
// wrapping) and perf_stall (LOAD cycles blocked by m_ready, saturating).
module matrix_mult_arbiter
  import matrix_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned NELEM = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*W-1:0]          req_a,
  input  logic [NREQ*W-1:0]          req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       m_valid,
  output logic [W-1:0]               m_a,
  output logic [W-1:0]               m_b,
  input  logic                       m_ready,
  input  logic                       mr_valid,
  input  logic [MATRIX_NELEM*W-1:0]  mr_c,
  output logic                       mr_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [MATRIX_NELEM*W-1:0]  rsp_c,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
`ifdef MATRIX_ARB_PERF_EN
  ,
  output logic [15:0]                perf_jobs,
  output logic [15:0]                perf_stall
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(NELEM);

  arb_state_t                  state_q, state_d;
  logic [IW-1:0]               grant_q, grant_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [MATRIX_NELEM*W-1:0]   rsp_c_q, rsp_c_d;

  logic [NREQ-1:0]             arb_gnt;
  logic [IW-1:0]               arb_idx;
  logic [W-1:0]                a_arr [NREQ];
  logic [W-1:0]                b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rsp_c_d    = rsp_c_q;
    req_ready  = '0;
    m_valid    = 1'b0;
    m_a        = '0;
    m_b        = '0;
    mr_ready   = 1'b0;
    rsp_valid  = '0;
    unique case (state_q)
      ARB_IDLE: begin
        // Grant only; no element is accepted in this cycle.
        if (|arb_gnt) begin
          grant_d    = arb_idx;
          beat_cnt_d = '0;
          state_d    = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        m_valid            = req_valid[grant_q];
        m_a                = a_arr[grant_q];
        m_b                = b_arr[grant_q];
        req_ready[grant_q] = m_ready;
        if (req_valid[grant_q] && m_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CW'(NELEM - 1)) begin
            beat_cnt_d = '0;
            state_d    = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        // mr_ready only here, so the multiplier holds its result otherwise.
        mr_ready = 1'b1;
        if (mr_valid) begin
          rsp_c_d = mr_c;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      rsp_c_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rsp_c_q    <= rsp_c_d;
    end
  end

  assign busy     = (state_q != ARB_IDLE);
  assign grant_id = grant_q;
  assign rsp_c    = rsp_c_q;

`ifdef MATRIX_ARB_PERF_EN
  logic [15:0] perf_jobs_q, perf_jobs_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_jobs_d  = perf_jobs_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ARB_RESP && rsp_ready[grant_q]) begin
      perf_jobs_d = perf_jobs_q + 16'd1;
    end
    if (state_q == ARB_LOAD && req_valid[grant_q] && !m_ready && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_jobs_q  <= perf_jobs_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

  // A result offered outside WAIT would be silently dropped.
  property p_mr_valid_in_wait;
    @(posedge clk) disable iff (!rst_n) mr_valid |-> (state_q == ARB_WAIT);
  endproperty
  a_mr_valid_in_wait: assert property (p_mr_valid_in_wait);

endmodule

// File: tb/tb_matrix_mult_arbiter.sv
// tb_matrix_mult_arbiter: self-checking bench for matrix_mult_arbiter with a
// behavioural multiplier and a job-level arbitration/result reference model.
module tb_matrix_mult_arbiter;
  import matrix_pkg::*;

  localparam int unsigned W    = 12;
  localparam int unsigned NREQ = 2;
  localparam int unsigned MAXJ = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0]      req_a, req_b;
  logic                   m_valid, m_ready, mr_valid, mr_ready, busy;
  logic [W-1:0]           m_a, m_b;
  logic [16*W-1:0]        mr_c, rsp_c;
  logic [0:0]             grant_id;
`ifdef MATRIX_ARB_PERF_EN
  logic [15:0]            perf_jobs, perf_stall;
`endif

  always #5 clk = ~clk;

  matrix_mult_arbiter #(.W(W), .NREQ(NREQ), .NELEM(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .m_valid(m_valid), .m_a(m_a), .m_b(m_b), .m_ready(m_ready),
    .mr_valid(mr_valid), .mr_c(mr_c), .mr_ready(mr_ready),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_ready(rsp_ready),
    .grant_id(grant_id), .busy(busy)
`ifdef MATRIX_ARB_PERF_EN
    , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
  );

  int unsigned n_cmp = 0, n_bad = 0;
  logic [W-1:0] job_a [MAXJ][16];
  logic [W-1:0] job_b [MAXJ][16];
  int unsigned  m_mode;        // 0: always ready, 1: toggle, 2: random
  int unsigned  last_beats;
  int           grant_log [$];
  int unsigned  model_ptr, exp_owner, jobs_model, stall_model;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 4x4 fixed-point (x.10) product, row-major element order, c[0] in LSBs.
  function automatic mat_flat_t matmul(input logic [W-1:0] a [16], input logic [W-1:0] b [16]);
    mat_flat_t r;
    longint    acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          acc += longint'(signed'(a[i*4+k])) * longint'(signed'(b[k*4+j]));
        end
        r[i*4+j] = W'(acc >>> 10);
      end
    end
    return r;
  endfunction

  // Behavioural multiplier: collects 16 beats, answers after 0..3 cycles,
  // holds its result until mr_ready.
  task automatic mult_model();
    logic [W-1:0] ma [16];
    logic [W-1:0] mb [16];
    int unsigned  cnt = 0, lat = 0;
    bit           drop = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mr_valid = 1'b0; m_ready = 1'b0; cnt = 0; drop = 0;
        continue;
      end
      if (drop) begin
        mr_valid = 1'b0; drop = 0; cnt = 0;
      end
      case (m_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (cnt >= 16 && !mr_valid) begin
        if (lat == 0) begin
          mr_valid = 1'b1;
          mr_c     = matmul(ma, mb);
        end else begin
          lat--;
        end
      end
      #2;
      if (m_valid && m_ready) begin
        if (cnt < 16) begin
          ma[cnt] = m_a;
          mb[cnt] = m_b;
        end
        cnt++;
        if (cnt == 16) lat = $urandom_range(0, 3);
      end
      if (mr_valid && mr_ready) begin
        last_beats = cnt;
        drop = 1;
      end
    end
  endtask

  // Job-level reference: round-robin owner prediction, exclusivity, perf counts.
  task automatic monitor();
    bit          pend = 0, in_job = 0, found;
    int unsigned load_beats = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        model_ptr = 0; pend = 0; in_job = 0; jobs_model = 0; stall_model = 0;
        continue;
      end
      if (pend) begin
        check_eq("grant_id", 256'(grant_id), 256'(exp_owner));
        check_eq("busy_set", 256'(busy), 256'(1));
        grant_log.push_back(int'(grant_id));
        pend = 0; in_job = 1; load_beats = 0;
      end
      if (!busy) check_eq("req_ready_idle", 256'(req_ready), 256'(0));
      else       check_eq("req_ready_owner", 256'(req_ready & ~(NREQ'(1) << exp_owner)), 256'(0));
      if (rsp_valid != '0) check_eq("rsp_owner", 256'(rsp_valid), 256'(NREQ'(1) << exp_owner));
      if (in_job && load_beats < 16 && req_valid[exp_owner] && !m_ready && stall_model != 16'hFFFF)
        stall_model++;
      if (m_valid && m_ready) load_beats++;
      if (|(rsp_valid & rsp_ready)) begin
        model_ptr  = (exp_owner + 1) % NREQ;
        jobs_model = (jobs_model + 1) % 65536;
        in_job     = 0;
      end
      if (!busy && (|req_valid)) begin
        found = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
          int unsigned cand = (model_ptr + off) % NREQ;
          if (!found && req_valid[cand]) begin
            exp_owner = cand;
            found = 1;
          end
        end
        pend = 1;
      end
    end
  endtask

  // One requester job: stream 16 pairs (optional pause/gaps), then take the result.
  task automatic run_req(input int unsigned r, input int unsigned j, input int unsigned pause_at,
                         input int unsigned pause_len, input int unsigned hold, input bit gaps);
    int unsigned k = 0, budget = 0, paused = 0;
    mat_flat_t   exp_c;
    exp_c = matmul(job_a[j], job_b[j]);
    while (k < 16 && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (k == pause_at && paused < pause_len) begin
        req_valid[r] = 1'b0;
        paused++;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        req_valid[r] = 1'b0;
      end else begin
        req_valid[r]      = 1'b1;
        req_a[r*W +: W]   = job_a[j][k];
        req_b[r*W +: W]   = job_b[j][k];
      end
      #2;
      if (req_valid[r] && req_ready[r]) k++;
    end
    check_eq("beats_sent", 256'(k), 256'(16));
    @(negedge clk);
    req_valid[r] = 1'b0;
    #2;
    budget = 0;
    while (!rsp_valid[r] && budget < 500) begin
      @(negedge clk);
      #2;
      budget++;
    end
    check_eq("rsp_arrives", 256'(rsp_valid[r]), 256'(1));
    check_eq("rsp_onehot", 256'(rsp_valid), 256'(NREQ'(1) << r));
    check_eq("mult_beats", 256'(last_beats), 256'(16));
    check_eq("rsp_c", 256'(rsp_c), 256'(exp_c));
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      #2;
      check_eq("rsp_hold", 256'(rsp_valid[r]), 256'(1));
      check_eq("rsp_stable", 256'(rsp_c), 256'(exp_c));
    end
    @(negedge clk);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned k, budget;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    m_ready = 1'b0; mr_valid = 1'b0; mr_c = '0; m_mode = 0; last_beats = 0;
    model_ptr = 0; exp_owner = 0; jobs_model = 0; stall_model = 0;
    for (int j = 0; j < MAXJ; j++) begin
      for (int e = 0; e < 16; e++) begin
        job_a[j][e] = W'($urandom);
        job_b[j][e] = W'($urandom);
      end
    end
    for (int e = 0; e < 16; e++) begin
      job_a[0][e] = (e % 5 == 0) ? W'(1024) : W'(0);
      job_b[0][e] = W'(e);
    end
    fork
      mult_model();
      monitor();
      begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", 256'(req_ready), 256'(0));
    check_eq("rst_m_valid",   256'(m_valid),   256'(0));
    check_eq("rst_m_a",       256'(m_a),       256'(0));
    check_eq("rst_m_b",       256'(m_b),       256'(0));
    check_eq("rst_mr_ready",  256'(mr_ready),  256'(0));
    check_eq("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check_eq("rst_rsp_c",     256'(rsp_c),     256'(0));
    check_eq("rst_busy",      256'(busy),      256'(0));
    check_eq("rst_grant_id",  256'(grant_id),  256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single job: identity times ramp returns the ramp
    run_req(0, 0, 99, 0, 0, 0);
    @(negedge clk);
    #2;
    check_eq("busy_drop", 256'(busy), 256'(0));

    // Contention from reset: 0, then 1, then 0 again
    pulse_reset();
    grant_log.delete();
    fork
      begin
        run_req(0, 1, 99, 0, 0, 0);
        run_req(0, 2, 99, 0, 0, 0);
      end
      run_req(1, 3, 99, 0, 0, 0);
    join
    check_eq("order_len", 256'(grant_log.size()), 256'(3));
    if (grant_log.size() == 3) begin
      check_eq("order_0", 256'(grant_log[0]), 256'(0));
      check_eq("order_1", 256'(grant_log[1]), 256'(1));
      check_eq("order_2", 256'(grant_log[2]), 256'(0));
    end

    // Backpressure: m_ready toggles, response held off for 5 cycles
    m_mode = 1;
    run_req(0, 4, 99, 0, 5, 0);
    m_mode = 0;

    // Starved source: req1 pauses 10 cycles after beat 7 while req0 waits
    fork
      run_req(1, 5, 7, 10, 0, 0);
      begin
        repeat (3) @(negedge clk);
        run_req(0, 6, 99, 0, 0, 0);
      end
    join

    // Reset mid-LOAD after beat 5
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_a[0 +: W] = job_a[7][0];
    req_b[0 +: W] = job_b[7][0];
    k = 0; budget = 0;
    while (k < 5 && budget < 200) begin
      #2;
      if (req_ready[0]) k++;
      budget++;
      if (k < 5) @(negedge clk);
    end
    check_eq("pre_rst_beats", 256'(k), 256'(5));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", 256'(req_ready), 256'(0));
    check_eq("arst_m_valid",   256'(m_valid),   256'(0));
    check_eq("arst_m_a",       256'(m_a),       256'(0));
    check_eq("arst_mr_ready",  256'(mr_ready),  256'(0));
    check_eq("arst_rsp_valid", 256'(rsp_valid), 256'(0));
    check_eq("arst_rsp_c",     256'(rsp_c),     256'(0));
    check_eq("arst_busy",      256'(busy),      256'(0));
    check_eq("arst_grant_id",  256'(grant_id),  256'(0));
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_eq("idle_after_rst", 256'(busy), 256'(0));
    grant_log.delete();
    fork
      run_req(1, 8, 99, 0, 0, 0);
      run_req(0, 9, 99, 0, 0, 0);
    join
    if (grant_log.size() > 0) check_eq("ptr_after_rst", 256'(grant_log[0]), 256'(0));
    else                      check_eq("ptr_after_rst", 256'(grant_log.size()), 256'(1));

    // Randomized traffic
    m_mode = 2;
    for (int unsigned rnd = 0; rnd < 4; rnd++) begin
      fork
        run_req(0, 10 + 2*rnd, $urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 4), 1);
        run_req(1, 11 + 2*rnd, $urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 4), 1);
      join
    end
    m_mode = 0;

`ifdef MATRIX_ARB_PERF_EN
    @(negedge clk);
    #2;
    check_eq("perf_jobs", 256'(perf_jobs), 256'(jobs_model));
    check_eq("perf_stall", 256'(perf_stall), 256'(stall_model));
    @(negedge clk);
    force dut.perf_stall_q = 16'hFFFF;
    @(negedge clk);
    release dut.perf_stall_q;
    stall_model = 16'hFFFF;
    m_mode = 1;
    run_req(0, 20, 99, 0, 0, 0);
    m_mode = 0;
    @(negedge clk);
    #2;
    check_eq("perf_stall_sat", 256'(perf_stall), 256'(16'hFFFF));
    check_eq("perf_jobs_end", 256'(perf_jobs), 256'(jobs_model));
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
